controle_escrita_banco: RTL and testbench
=========================================

Name: controle_escrita_banco

Overview:
- Upstream write-port controller for the register bank.
- Conditions the raw board push-buttons: 2-flop synchronizer, then per-key debounce.
- Turns each debounced press into exactly one single-cycle write (enable, address, data) on the register-bank write port.
- Data comes from the switch fields. A second key writes zero (register clear). A write counter and busy flag are exposed for display/debug.

Parameters:
- DATA_W, 16, width of register data written to the bank.
- ADDR_W, 4, register address width (16 registers).
- DEB_CYCLES, 1000000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz). Benches override to 4.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous reset, active-high.
- key_wr_n  in  1  raw push-button, active-low: write sw_data.
- key_clr_n  in  1  raw push-button, active-low: write zero.
- sw_addr  in  ADDR_W  target register address from switches.
- sw_data  in  DATA_W  write data from switches.
- wr_en  out  1  write strobe to the register bank, one cycle per accepted press.
- wr_addr  out  ADDR_W  write address, valid while wr_en=1.
- wr_data  out  DATA_W  write data, valid while wr_en=1.
- busy  out  1  high from write until both keys are released (debounced).
- wr_count  out  8  number of writes issued, modulo 256.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). All state changes occur on the rising edge of clk.
- Reset values:
  - Outputs: wr_en=0, wr_addr=0, wr_data=0, busy=0, wr_count=0.
  - Internal: sync flops=1, accepted levels=1 (released), debounce counters=0, FSM=IDLE.
  - rst overrides everything in the same edge, including mid-write and mid-debounce.
- Synchronizer: 2 flops per key. No logic acts on the raw inputs.
- Debounce, per key:
  - The counter increments each cycle the synchronized level differs from the accepted level.
  - The counter clears to 0 on any cycle where they match.
  - When a differing cycle is the DEB_CYCLES-th in a row, the accepted level takes the synchronized value at that edge and the counter clears.
- Press event: accepted level 1->0, detected against a registered copy of the accepted level. Release is accepted level 0->1.
- FSM states: IDLE, WRITE, WAIT_REL.
  - IDLE: on a press event of either key, latch wr_addr<=sw_addr, and latch wr_data<=sw_data (write key) or 0 (clear key). Go to WRITE.
  - WRITE: wr_en=1 for exactly this one cycle; wr_count<=wr_count+1 (wraps 255->0). Go to WAIT_REL unconditionally.
  - WAIT_REL: stay until both accepted levels are 1, then go to IDLE. Press events of either key in this state are discarded, never queued.
- busy=1 in WRITE and WAIT_REL, 0 in IDLE. Registered: changes on the same edge as the state.
- Simultaneous press events in the same cycle: one write only, clear wins (wr_data=0).
- Latency: let e0 be the first edge sampling the raw key low, with the raw key held stable. wr_en is high in the cycle after edge e(DEB_CYCLES+2), i.e. 7 edges total for DEB_CYCLES=4. sw_addr/sw_data are sampled at that same edge; later switch changes do not affect wr_addr/wr_data until the next write.
- wr_addr/wr_data hold their last written values after wr_en drops.
- Glitches: any low pulse shorter than DEB_CYCLES synchronized cycles produces no write.
- Reset while a key is held: after rst deasserts, the accepted level is 1 and the key is low, so a new press is detected and written after DEB_CYCLES+3 edges. This is required behaviour.

Test Plan (DEB_CYCLES=4):
- rst high 3 cycles, then low, keys high for 20 cycles -> wr_en, busy, wr_count, wr_addr, wr_data stay 0 throughout.
- sw_addr=3, sw_data=0x00A5, key_wr_n low for 20 cycles then high -> exactly one wr_en pulse, 7 edges after the first low sample, with wr_addr=3, wr_data=0x00A5. Then wr_count=1; busy=1 until 7 edges after the raw key returns high, then 0.
- Bounce: key_wr_n pattern low 3 / high 1, repeated 5 times, then high -> no wr_en, wr_count=0, busy=0.
- sw_addr=7, sw_data=0xFFFF, key_clr_n pressed 20 cycles -> one wr_en with wr_addr=7, wr_data=0x0000. Press key_wr_n while clr is still held -> no second write. Release both -> busy falls.
- Both keys fall in the same cycle with sw_data=0x1234 -> single write, wr_data=0. Separately, 256 distinct press/release cycles -> wr_count returns to 0.
- Assert rst during WAIT_REL with key_wr_n held low -> all outputs 0 next cycle. Deassert rst with the key still low -> one new write 7 edges later, wr_count=1.

Source files
------------

// File: rtl/controle_escrita_banco.sv
// Register-bank write-port controller: synchronizes and debounces two push-buttons,
// and turns each accepted press into a single-cycle write strobe with latched address/data.
module controle_escrita_banco #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_wr_n,
  input  logic              key_clr_n,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic [7:0]        wr_count
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam int KEY_WR  = 0;
  localparam int KEY_CLR = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  logic [1:0]       raw_s;
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       acc_q;
  logic [1:0]       acc_d;
  logic [1:0]       acc_prev_q;
  logic [1:0]       press_s;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  state_t              state_q;
  state_t              state_d;
  logic                wr_en_q;
  logic                wr_en_d;
  logic                busy_q;
  logic                busy_d;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q;
  logic [DATA_W-1:0]   wr_data_d;
  logic [7:0]          wr_count_q;
  logic [7:0]          wr_count_d;

  assign raw_s = {key_clr_n, key_wr_n};

  // Synchronizer, accepted levels and debounce counters for both keys
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      acc_q      <= 2'b11;
      acc_prev_q <= 2'b11;
      cnt_q[0]   <= {CNT_W{1'b0}};
      cnt_q[1]   <= {CNT_W{1'b0}};
    end else begin
      sync1_q    <= raw_s;
      sync2_q    <= sync1_q;
      acc_q      <= acc_d;
      acc_prev_q <= acc_q;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
    end
  end

  // Debounce: accept a new level on the DEB_CYCLES-th consecutive differing cycle
  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = {CNT_W{1'b0}};
      if (sync2_q[k] != acc_q[k]) begin
        if (cnt_q[k] == CNT_LAST) begin
          acc_d[k] = sync2_q[k];
          cnt_d[k] = {CNT_W{1'b0}};
        end else begin
          cnt_d[k] = cnt_q[k] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_d[k] = {CNT_W{1'b0}};
      end
    end
  end

  assign press_s = acc_prev_q & ~acc_q;

  // FSM state and registered write-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      wr_addr_q  <= {ADDR_W{1'b0}};
      wr_data_q  <= {DATA_W{1'b0}};
      wr_count_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Next state; press events outside IDLE are dropped, clear wins on a tie
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_count_d = wr_count_q;
    case (state_q)
      IDLE: begin
        if (press_s != 2'b00) begin
          state_d   = WRITE;
          wr_addr_d = sw_addr;
          if (press_s[KEY_CLR]) begin
            wr_data_d = {DATA_W{1'b0}};
          end else begin
            wr_data_d = sw_data;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        state_d    = WAIT_REL;
        wr_count_d = wr_count_q + 8'd1;
      end
      WAIT_REL: begin
        if (acc_q == 2'b11) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_REL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    wr_en_d = (state_d == WRITE);
    busy_d  = (state_d != IDLE);
  end

  assign wr_en    = wr_en_q;
  assign busy     = busy_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_controle_escrita_banco.sv
// Scoreboard bench for controle_escrita_banco with DEB_CYCLES=4: directed key presses
// queue expected writes; a negedge monitor checks every wr_en pulse against the queue.
module tb_controle_escrita_banco;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEB    = 4;
  localparam int LAT    = DEB + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              key_wr_n;
  logic              key_clr_n;
  logic [ADDR_W-1:0] sw_addr;
  logic [DATA_W-1:0] sw_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic [7:0]        wr_count;

  controle_escrita_banco #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .key_wr_n(key_wr_n), .key_clr_n(key_clr_n),
    .sw_addr(sw_addr), .sw_data(sw_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                at_cyc;
    logic [7:0]        cnt;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [7:0] cnt_mark;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue one write expected LAT edges after the current drive point.
  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_t e;
    e.addr   = a;
    e.data   = d;
    e.at_cyc = cyc + LAT;
    e.cnt    = exp_cnt;
    sb_q.push_back(e);
    exp_cnt = exp_cnt + 8'd1;
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_write: got wr_en=1 addr=%0h data=%0h, required no write (cycle %0d)",
                 wr_addr, wr_data, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(wr_data), 32'(mon_e.data));
        chk("wr_latency_cycle", 32'(cyc), 32'(mon_e.at_cyc));
        chk("wr_count_at_write", 32'(wr_count), 32'(mon_e.cnt));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    key_wr_n  = 1'b1;
    key_clr_n = 1'b1;
    sw_addr   = 4'd0;
    sw_data   = 16'h0000;
    tick(3);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wr_count", 32'(wr_count), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_data", 32'(wr_data), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_wr_count", 32'(wr_count), 32'd0);
    end

    // Single write press, switches change afterwards
    sw_addr  = 4'd3;
    sw_data  = 16'h00A5;
    key_wr_n = 1'b0;
    expect_write(4'd3, 16'h00A5);
    tick(10);
    sw_addr = 4'd6;
    sw_data = 16'h5555;
    tick(10);
    chk("hold_wr_addr", 32'(wr_addr), 32'd3);
    chk("hold_wr_data", 32'(wr_data), 32'h00A5);
    chk("count_after_first", 32'(wr_count), 32'd1);
    chk("busy_while_held", 32'(busy), 32'd1);
    key_wr_n = 1'b1;
    tick(LAT - 1);
    chk("busy_before_release_accept", 32'(busy), 32'd1);
    tick(1);
    chk("busy_after_release", 32'(busy), 32'd0);
    tick(5);

    // Bounce shorter than the debounce window
    for (int i = 0; i < 5; i++) begin
      key_wr_n = 1'b0;
      tick(3);
      key_wr_n = 1'b1;
      tick(1);
    end
    tick(12);
    chk("bounce_wr_count", 32'(wr_count), 32'(exp_cnt));
    chk("bounce_busy", 32'(busy), 32'd0);

    // Clear key, then write key pressed while clear held
    sw_addr   = 4'd7;
    sw_data   = 16'hFFFF;
    key_clr_n = 1'b0;
    expect_write(4'd7, 16'h0000);
    tick(20);
    key_wr_n = 1'b0;
    tick(20);
    chk("no_second_write_count", 32'(wr_count), 32'(exp_cnt));
    chk("busy_both_held", 32'(busy), 32'd1);
    key_wr_n  = 1'b1;
    key_clr_n = 1'b1;
    tick(LAT - 1);
    chk("busy_before_both_release", 32'(busy), 32'd1);
    tick(1);
    chk("busy_after_both_release", 32'(busy), 32'd0);
    tick(3);

    // Simultaneous press: clear wins
    sw_addr   = 4'd5;
    sw_data   = 16'h1234;
    key_wr_n  = 1'b0;
    key_clr_n = 1'b0;
    expect_write(4'd5, 16'h0000);
    tick(20);
    key_wr_n  = 1'b1;
    key_clr_n = 1'b1;
    tick(10);
    chk("simul_wr_count", 32'(wr_count), 32'(exp_cnt));

    // 256 press/release cycles wrap the counter back to its starting value
    cnt_mark = wr_count;
    for (int i = 0; i < 256; i++) begin
      sw_addr  = 4'(i);
      sw_data  = 16'(i * 16'd257);
      key_wr_n = 1'b0;
      expect_write(4'(i), 16'(i * 16'd257));
      tick(LAT + 1);
      key_wr_n = 1'b1;
      tick(LAT + 1);
    end
    chk("wrap_wr_count", 32'(wr_count), 32'(cnt_mark));
    chk("wrap_model_count", 32'(wr_count), 32'(exp_cnt));

    // Reset in WAIT_REL with key held, then a fresh write after release of rst
    sw_addr  = 4'd9;
    sw_data  = 16'hBEEF;
    key_wr_n = 1'b0;
    expect_write(4'd9, 16'hBEEF);
    tick(12);
    chk("busy_before_reset", 32'(busy), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wr_count", 32'(wr_count), 32'd0);
    chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
    chk("midrst_wr_data", 32'(wr_data), 32'd0);
    rst     = 1'b0;
    exp_cnt = 8'd0;
    expect_write(4'd9, 16'hBEEF);
    tick(12);
    chk("post_reset_wr_count", 32'(wr_count), 32'd1);
    chk("post_reset_busy", 32'(busy), 32'd1);
    key_wr_n = 1'b1;
    tick(10);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick(1);
    if (sb_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL missing_writes: got %0d writes still pending, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
